nios_onchip_mem_bist: RTL and testbench

//  - Upstream Avalon-MM master for the 8192x32 single-port on-chip RAM (s2 side).
//  - Fills an address range with a seeded incrementing pattern, then reads it back and compares.
//  - Reports pass/fail, a saturating error count and the first failing address to the Nios.
//  - Lets software qualify the RAM at boot without spending CPU cycles on it.

---
 rtl/nios_onchip_mem_bist.sv | 261 ++++++++++++++++++++++++++
 tb/tb_nios_onchip_mem_bist.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_onchip_mem_bist.sv
// Avalon-MM BIST master for the 8192x32 on-chip RAM: seeded fill, read-back compare, error report.
// Define MEM_BIST_ERR_DATA_EN to add the first_err_data / first_err_expected outputs.
module nios_onchip_mem_bist #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
`ifdef MEM_BIST_ERR_DATA_EN
  output logic [DATA_W-1:0]   first_err_data,
  output logic [DATA_W-1:0]   first_err_expected,
`endif
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
  logic              mem_clken_q, mem_clken_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              pass_q, pass_d;
`ifdef MEM_BIST_ERR_DATA_EN
  logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
  logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
`endif

  logic start_ok;
  logic stop;
  logic at_last;
  logic stepping;
  logic mismatch;

  assign start_ok = (state_q == S_IDLE) && start;
  assign stop     = (state_q != S_IDLE) && abort;
  assign at_last  = (addr_q == last_q);
  assign stepping = ((state_q == S_WRITE) || (state_q == S_READ)) && !abort;
  // A read in flight when abort arrives is dropped without being compared.
  assign mismatch = rd_valid_q && !abort && (mem_readdata != exp_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode[0])      state_d = S_WRITE;
          else if (mode[1]) state_d = S_READ;
          else              state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if (abort)        state_d = S_IDLE;
        else if (at_last) state_d = mode_q[1] ? S_READ : S_DONE;
      end
      S_READ: begin
        if (abort)        state_d = S_IDLE;
        else if (at_last) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = abort ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    base_d = base_q;
    last_d = last_q;
    seed_d = seed_q;
    addr_d = addr_q;
    pat_d  = pat_q;
    if (start_ok) begin
      mode_d = mode;
      base_d = base_addr;
      last_d = last_addr;
      seed_d = seed;
      addr_d = base_addr;
      pat_d  = seed;
    end else if (stepping) begin
      // Rewinding at the end of the write pass lines the counter up for the read pass.
      if (at_last) begin
        addr_d = base_q;
        pat_d  = seed_q;
      end else begin
        addr_d = addr_q + ADDR_ONE;
        pat_d  = pat_q + DATA_ONE;
      end
    end

    mem_cs_d    = (state_d == S_WRITE) || (state_d == S_READ);
    mem_wr_d    = (state_d == S_WRITE);
    mem_be_d    = {BE_W{mem_cs_d}};
    mem_wd_d    = mem_wr_d ? pat_d : '0;
    mem_clken_d = (state_d != S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q == S_DONE) && !abort;

    rd_valid_d = (state_q == S_READ) && !abort;
    exp_d      = pat_q;
    rd_addr_d  = addr_q;

    aborted_d = aborted_q;
    if (start_ok)  aborted_d = 1'b0;
    else if (stop) aborted_d = 1'b1;

    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
`ifdef MEM_BIST_ERR_DATA_EN
    first_err_data_d = first_err_data_q;
    first_err_exp_d  = first_err_exp_q;
`endif
    if (start_ok) begin
      err_count_d      = '0;
      first_err_addr_d = '0;
`ifdef MEM_BIST_ERR_DATA_EN
      first_err_data_d = '0;
      first_err_exp_d  = '0;
`endif
    end else if (mismatch) begin
      if (err_count_q != '1) err_count_d = err_count_q + ERR_ONE;
      if (err_count_q == '0) begin
        first_err_addr_d = rd_addr_q;
`ifdef MEM_BIST_ERR_DATA_EN
        first_err_data_d = mem_readdata;
        first_err_exp_d  = exp_q;
`endif
      end
    end

    pass_d = pass_q;
    if (start_ok)    pass_d = 1'b0;
    else if (done_d) pass_d = (err_count_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q           <= '0;
      base_q           <= '0;
      last_q           <= '0;
      seed_q           <= '0;
      addr_q           <= '0;
      pat_q            <= '0;
      mem_be_q         <= '0;
      mem_cs_q         <= 1'b0;
      mem_wr_q         <= 1'b0;
      mem_wd_q         <= '0;
      mem_clken_q      <= 1'b0;
      rd_valid_q       <= 1'b0;
      exp_q            <= '0;
      rd_addr_q        <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
      pass_q           <= 1'b0;
`ifdef MEM_BIST_ERR_DATA_EN
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
`endif
    end else begin
      mode_q           <= mode_d;
      base_q           <= base_d;
      last_q           <= last_d;
      seed_q           <= seed_d;
      addr_q           <= addr_d;
      pat_q            <= pat_d;
      mem_be_q         <= mem_be_d;
      mem_cs_q         <= mem_cs_d;
      mem_wr_q         <= mem_wr_d;
      mem_wd_q         <= mem_wd_d;
      mem_clken_q      <= mem_clken_d;
      rd_valid_q       <= rd_valid_d;
      exp_q            <= exp_d;
      rd_addr_q        <= rd_addr_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      aborted_q        <= aborted_d;
      pass_q           <= pass_d;
`ifdef MEM_BIST_ERR_DATA_EN
      first_err_data_q <= first_err_data_d;
      first_err_exp_q  <= first_err_exp_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
`ifdef MEM_BIST_ERR_DATA_EN
  assign first_err_data     = first_err_data_q;
  assign first_err_expected = first_err_exp_q;
`endif
  assign mem_address    = addr_q;
  assign mem_byteenable = mem_be_q;
  assign mem_chipselect = mem_cs_q;
  assign mem_write      = mem_wr_q;
  assign mem_writedata  = mem_wd_q;
  assign mem_clken      = mem_clken_q;

endmodule

// File: tb/tb_nios_onchip_mem_bist.sv
// Self-checking bench for nios_onchip_mem_bist: RAM model plus a range-level reference model.
// A second instance with a 4-bit error counter shares the stimulus and sees an all-zero RAM.
module tb_nios_onchip_mem_bist;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] seed;

  logic          busy, done, aborted, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  logic          busy4, done4, aborted4, pass4;
  logic [3:0]    err_count4;
  logic [AW-1:0] first_err_addr4;
  logic [AW-1:0] mem_address4;
  logic [3:0]    mem_byteenable4;
  logic          mem_chipselect4, mem_write4, mem_clken4;
  logic [DW-1:0] mem_writedata4;
  logic [DW-1:0] zero_rd;

`ifdef MEM_BIST_ERR_DATA_EN
  logic [DW-1:0] first_err_data, first_err_expected;
  logic [DW-1:0] first_err_data4, first_err_expected4;
`endif

  nios_onchip_mem_bist #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .last_addr(last_addr), .seed(seed),
    .busy(busy), .done(done), .aborted(aborted), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
`ifdef MEM_BIST_ERR_DATA_EN
    .first_err_data(first_err_data), .first_err_expected(first_err_expected),
`endif
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  nios_onchip_mem_bist #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .last_addr(last_addr), .seed(seed),
    .busy(busy4), .done(done4), .aborted(aborted4), .pass(pass4),
    .err_count(err_count4), .first_err_addr(first_err_addr4),
`ifdef MEM_BIST_ERR_DATA_EN
    .first_err_data(first_err_data4), .first_err_expected(first_err_expected4),
`endif
    .mem_address(mem_address4), .mem_byteenable(mem_byteenable4),
    .mem_chipselect(mem_chipselect4), .mem_write(mem_write4),
    .mem_writedata(mem_writedata4), .mem_clken(mem_clken4),
    .mem_readdata(zero_rd)
  );

  assign zero_rd = '0;

  // RAM model: one-cycle read latency, optional per-address bit flips on read.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    be;
  } wr_t;

  logic [DW-1:0] ram  [DEPTH];
  logic [DW-1:0] flip [DEPTH];
  logic          ram_init;
  wr_t           wlog[$];
  logic [AW-1:0] rlog[$];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        wlog.push_back('{mem_address, mem_writedata, mem_byteenable});
      end else begin
        mem_readdata <= ram[mem_address] ^ flip[mem_address];
        rlog.push_back(mem_address);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one BIST pass and checks it against a model built from the range rules alone.
  task automatic applyStimulus(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] l,
                               input logic [DW-1:0] s, input string tag);
    int n, ai, errs, errs4, exp_lat, cyc, wb, rb, bad;
    logic [AW-1:0] a, first_a, first4_a;
    logic [DW-1:0] val, expv, first_val, first_exp;
    n = ((int'(l) - int'(b)) & (DEPTH - 1)) + 1;
    errs = 0; errs4 = 0; first_a = '0; first4_a = '0; first_val = '0; first_exp = '0;
    for (int i = 0; i < n; i++) begin
      ai   = (int'(b) + i) & (DEPTH - 1);
      a    = ai[AW-1:0];
      expv = s + i;
      val  = (m[0] ? expv : ram[a]) ^ flip[a];
      if (m[1]) begin
        if (val !== expv) begin
          if (errs == 0) begin first_a = a; first_val = val; first_exp = expv; end
          errs++;
        end
        if (expv !== '0) begin
          if (errs4 == 0) first4_a = a;
          errs4++;
        end
      end
    end
    exp_lat = n * int'(m[0]) + (n + 1) * int'(m[1]) + 1;
    wb = wlog.size();
    rb = rlog.size();

    @(negedge clk);
    mode = m; base_addr = b; last_addr = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, exp_lat);
    checkOutput({tag, "_done4"}, done4, 1);
    checkOutput({tag, "_busy_at_done"}, busy, 0);
    checkOutput({tag, "_aborted"}, aborted, 0);
    checkOutput({tag, "_pass"}, pass, (errs == 0) ? 1 : 0);
    checkOutput({tag, "_err_count"}, err_count, (errs > 65535) ? 65535 : errs);
    checkOutput({tag, "_first_err_addr"}, first_err_addr, first_a);
    checkOutput({tag, "_err_count4"}, err_count4, (errs4 > 15) ? 15 : errs4);
    checkOutput({tag, "_first_err_addr4"}, first_err_addr4, first4_a);
    checkOutput({tag, "_pass4"}, pass4, (errs4 == 0) ? 1 : 0);
`ifdef MEM_BIST_ERR_DATA_EN
    checkOutput({tag, "_first_err_data"}, first_err_data, first_val);
    checkOutput({tag, "_first_err_expected"}, first_err_expected, first_exp);
`endif
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, done, 0);

    checkOutput({tag, "_write_count"}, wlog.size() - wb, n * int'(m[0]));
    bad = 0;
    for (int i = 0; i < wlog.size() - wb; i++) begin
      ai = (int'(b) + i) & (DEPTH - 1);
      if (wlog[wb+i].a !== ai[AW-1:0] || wlog[wb+i].d !== s + i || wlog[wb+i].be !== 4'hF) bad++;
    end
    checkOutput({tag, "_write_seq"}, bad, 0);
    checkOutput({tag, "_read_count"}, rlog.size() - rb, n * int'(m[1]));
    bad = 0;
    for (int i = 0; i < rlog.size() - rb; i++) begin
      ai = (int'(b) + i) & (DEPTH - 1);
      if (rlog[rb+i] !== ai[AW-1:0]) bad++;
    end
    checkOutput({tag, "_read_seq"}, bad, 0);
  endtask

  initial begin
    int wb, saw_done, ti, len;
    logic [AW-1:0] fa, rb_addr, rl_addr;

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0;
    base_addr = '0; last_addr = '0; seed = '0; ram_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) flip[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_first_err_addr", first_err_addr, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_mem_byteenable", mem_byteenable, 0);
    checkOutput("rst_mem_chipselect", mem_chipselect, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_mem_writedata", mem_writedata, 0);
    checkOutput("rst_mem_clken", mem_clken, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] full run, clean RAM");
    applyStimulus(2'd3, 13'd0, 13'd15, 32'h100, "m3_clean");

    $display("[TB] full run, bit0 flipped at address 5");
    flip[5] = 32'h1;
    applyStimulus(2'd3, 13'd0, 13'd15, 32'h100, "m3_flip5");
    flip[5] = '0;

    $display("[TB] write-only run wrapping through the top address");
    applyStimulus(2'd1, 13'd8190, 13'd1, 32'hCAFE0000, "m1_wrap");

    $display("[TB] check-only run over 0..31, seed 1");
    applyStimulus(2'd2, 13'd0, 13'd31, 32'h1, "m2_sat");

    $display("[TB] mode 0 run");
    applyStimulus(2'd0, 13'd40, 13'd50, 32'h5, "m0");

    $display("[TB] abort on third write cycle, with an ignored start");
    wb = wlog.size();
    @(negedge clk);
    mode = 2'd1; base_addr = 13'd100; last_addr = 13'd199; seed = 32'hA000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd3; base_addr = 13'd5000; seed = 32'h0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_aborted", aborted, 1);
    checkOutput("abort_cs", mem_chipselect, 0);
    checkOutput("abort_wr", mem_write, 0);
    checkOutput("abort_clken", mem_clken, 0);
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_done", saw_done, 0);
    checkOutput("abort_sticky", aborted, 1);
    checkOutput("abort_write_count", wlog.size() - wb, 3);
    ti = 0;
    for (int i = 0; i < wlog.size() - wb && i < 3; i++)
      if (wlog[wb+i].a !== 13'(100 + i) || wlog[wb+i].d !== 32'hA000 + i) ti++;
    checkOutput("abort_write_seq", ti, 0);

    $display("[TB] reset in the middle of a read pass");
    @(negedge clk);
    mode = 2'd2; base_addr = 13'd0; last_addr = 13'd999; seed = 32'h77770000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_err_count", err_count, 0);
    checkOutput("midrst_first_err_addr", first_err_addr, 0);
    checkOutput("midrst_cs", mem_chipselect, 0);
    checkOutput("midrst_clken", mem_clken, 0);
    checkOutput("midrst_address", mem_address, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'd3, 13'd300, 13'd340, 32'h12345678, "after_rst");

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      len     = $urandom_range(1, 48);
      ti      = $urandom_range(0, DEPTH - 1);
      rb_addr = ti[AW-1:0];
      ti      = (int'(rb_addr) + len - 1) & (DEPTH - 1);
      rl_addr = ti[AW-1:0];
      ti      = (int'(rb_addr) + $urandom_range(0, len - 1)) & (DEPTH - 1);
      fa      = ti[AW-1:0];
      if ($urandom_range(0, 1) == 1) flip[fa] = 32'h1 << $urandom_range(0, 31);
      applyStimulus(2'($urandom_range(0, 3)), rb_addr, rl_addr, $urandom, $sformatf("rand%0d", r));
      flip[fa] = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
